// File: rtl/gin_pkg.sv
// Shared types and constants for the global input network (GIN) multicast fabric.
package gin_pkg;

  typedef enum logic [1:0] {
    StUncfg,
    StLoadRow,
    StLoadCol,
    StRun
  } gin_state_e;

  localparam int unsigned DropCntW = 16;

  // All-ones tag: broadcast when used as a tag, disable when loaded as an ID.
  function automatic logic [31:0] bcast_id(input int unsigned id_w);
    return (32'd1 << id_w) - 32'd1;
  endfunction

endpackage

// File: rtl/gin_id_match.sv
// Tag/ID comparator: a BCAST tag hits every enabled ID, a BCAST ID never hits.
module gin_id_match
  import gin_pkg::*;
#(
  parameter int unsigned ID_W = 5
) (
  input  logic [ID_W-1:0] id_i,
  input  logic [ID_W-1:0] tag_i,
  output logic            hit_o
);

  localparam logic [ID_W-1:0] Bcast = ID_W'(bcast_id(ID_W));

  always_comb begin
    hit_o = (id_i != Bcast) && ((tag_i == Bcast) || (tag_i == id_i));
  end

endmodule

// File: rtl/gin_multicast_net.sv
// GIN multicast network: scan-loaded row/column IDs, one holding register,
// all-targets-ready delivery and a saturating count of words that had no target.
module gin_multicast_net
  import gin_pkg::*;
#(
  parameter int unsigned ROWS   = 12,
  parameter int unsigned COLS   = 14,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ID_W   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic                   cfg_id_valid,
  input  logic [ID_W-1:0]        cfg_id,
  output logic                   cfg_busy,
  output logic                   cfg_done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [ID_W-1:0]        in_row_tag,
  input  logic [ID_W-1:0]        in_col_tag,
  output logic [ROWS*COLS-1:0]   pe_valid,
  input  logic [ROWS*COLS-1:0]   pe_ready,
  output logic [DATA_W-1:0]      pe_data,
  output logic [DropCntW-1:0]    drop_cnt
);

  localparam int unsigned NumPe   = ROWS * COLS;
  localparam int unsigned LdW     = (NumPe > 1) ? $clog2(NumPe) : 1;
  localparam int unsigned RowIdxW = (ROWS > 1) ? $clog2(ROWS) : 1;

  gin_state_e          state_q, state_d;
  logic [LdW-1:0]      ld_cnt_q, ld_cnt_d;
  logic [ID_W-1:0]     row_id_q [ROWS];
  logic [ID_W-1:0]     row_id_d [ROWS];
  logic [ID_W-1:0]     col_id_q [NumPe];
  logic [ID_W-1:0]     col_id_d [NumPe];
  logic                cfg_done_q, cfg_done_d;
  logic                hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic [ID_W-1:0]     hold_row_q, hold_row_d;
  logic [ID_W-1:0]     hold_col_q, hold_col_d;
  logic [DropCntW-1:0] drop_cnt_q, drop_cnt_d;

  logic [ROWS-1:0]  row_hit;
  logic [NumPe-1:0] col_hit;
  logic [NumPe-1:0] target;
  logic             fire;
  logic             start_ok;
  logic             accept;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    gin_id_match #(
      .ID_W (ID_W)
    ) u_row_match (
      .id_i  (row_id_q[r]),
      .tag_i (hold_row_q),
      .hit_o (row_hit[r])
    );
  end

  for (genvar i = 0; i < NumPe; i++) begin : g_pe
    gin_id_match #(
      .ID_W (ID_W)
    ) u_col_match (
      .id_i  (col_id_q[i]),
      .tag_i (hold_col_q),
      .hit_o (col_hit[i])
    );
    assign target[i] = row_hit[i / COLS] && col_hit[i];
  end

  // A reload request beats a new word; it is only taken with the holding register empty.
  always_comb begin
    fire     = hold_valid_q && (&(~target | pe_ready));
    start_ok = cfg_start && ((state_q == StUncfg) || ((state_q == StRun) && !hold_valid_q));
    in_ready = (state_q == StRun) && !start_ok && (!hold_valid_q || fire);
    accept   = in_valid && in_ready;
  end

  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    row_id_d   = row_id_q;
    col_id_d   = col_id_q;
    cfg_done_d = 1'b0;
    if (start_ok) begin
      state_d  = StLoadRow;
      ld_cnt_d = '0;
    end else begin
      unique case (state_q)
        StLoadRow: begin
          if (cfg_id_valid) begin
            row_id_d[ld_cnt_q[RowIdxW-1:0]] = cfg_id;
            if (ld_cnt_q == LdW'(ROWS - 1)) begin
              state_d  = StLoadCol;
              ld_cnt_d = '0;
            end else begin
              ld_cnt_d = ld_cnt_q + 1'b1;
            end
          end
        end
        StLoadCol: begin
          if (cfg_id_valid) begin
            col_id_d[ld_cnt_q] = cfg_id;
            if (ld_cnt_q == LdW'(NumPe - 1)) begin
              state_d    = StRun;
              ld_cnt_d   = '0;
              cfg_done_d = 1'b1;
            end else begin
              ld_cnt_d = ld_cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_row_d   = hold_row_q;
    hold_col_d   = hold_col_q;
    drop_cnt_d   = drop_cnt_q;
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = in_data;
      hold_row_d   = in_row_tag;
      hold_col_d   = in_col_tag;
    end else if (fire) begin
      hold_valid_d = 1'b0;
    end
    if (fire && (target == '0) && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_comb begin
    cfg_busy = (state_q == StLoadRow) || (state_q == StLoadCol);
    cfg_done = cfg_done_q;
    pe_valid = {NumPe{hold_valid_q}} & target;
    pe_data  = hold_data_q;
    drop_cnt = drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StUncfg;
      ld_cnt_q     <= '0;
      row_id_q     <= '{default: '0};
      col_id_q     <= '{default: '0};
      cfg_done_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_row_q   <= '0;
      hold_col_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      ld_cnt_q     <= ld_cnt_d;
      row_id_q     <= row_id_d;
      col_id_q     <= col_id_d;
      cfg_done_q   <= cfg_done_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_row_q   <= hold_row_d;
      hold_col_q   <= hold_col_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_gin_multicast_net.sv
// Self-checking bench for gin_multicast_net: vector table, directed corner sequences and
// randomized traffic checked against a per-PE match model.
module tb_gin_multicast_net;

  localparam int ROWS   = 12;
  localparam int COLS   = 14;
  localparam int DATA_W = 16;
  localparam int ID_W   = 5;
  localparam int N      = ROWS * COLS;
  localparam logic [ID_W-1:0] BC = 5'h1F;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start;
  logic              cfg_id_valid;
  logic [ID_W-1:0]   cfg_id;
  logic              cfg_busy;
  logic              cfg_done;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ID_W-1:0]   in_row_tag;
  logic [ID_W-1:0]   in_col_tag;
  logic [N-1:0]      pe_valid;
  logic [N-1:0]      pe_ready;
  logic [DATA_W-1:0] pe_data;
  logic [15:0]       drop_cnt;

  gin_multicast_net #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_id_valid (cfg_id_valid),
    .cfg_id       (cfg_id),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_row_tag   (in_row_tag),
    .in_col_tag   (in_col_tag),
    .pe_valid     (pe_valid),
    .pe_ready     (pe_ready),
    .pe_data      (pe_data),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0]   rt;
    logic [ID_W-1:0]   ct;
    logic [DATA_W-1:0] data;
    int                cnt;
    int                bitn;
  } vec_t;

  vec_t vecs [8];

  // Reference model state
  logic [ID_W-1:0]   m_row [ROWS];
  logic [ID_W-1:0]   m_col [N];
  bit                m_run, m_hv, m_acc;
  logic [DATA_W-1:0] m_data;
  logic [ID_W-1:0]   m_rt, m_ct;
  int                m_drop;
  int                n_fires;
  logic [DATA_W-1:0] fired_q [$];

  int           n_chk = 0;
  int           n_fail = 0;
  logic [N-1:0] e_mask;
  int           base, nf, qs;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] model_target(input logic [ID_W-1:0] rt,
                                                input logic [ID_W-1:0] ct);
    logic [N-1:0] t;
    bit rh, ch;
    t = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        rh = (m_row[r] != BC) && (rt == BC || rt == m_row[r]);
        ch = (m_col[r*COLS+c] != BC) && (ct == BC || ct == m_col[r*COLS+c]);
        t[r*COLS+c] = rh && ch;
      end
    end
    return t;
  endfunction

  function automatic logic [ID_W-1:0] pick_tag();
    int v;
    v = $urandom_range(0, 15);
    if (v == 14) return 5'd20;
    if (v == 15) return BC;
    return ID_W'(v);
  endfunction

  task automatic model_reset();
    m_run  = 0;
    m_hv   = 0;
    m_acc  = 0;
    m_data = '0;
    m_drop = 0;
  endtask

  // Entered at a negedge with inputs applied; checks this cycle, advances the model,
  // returns at the next negedge.
  task automatic step();
    logic [N-1:0] tgt;
    bit fire, exp_rdy;
    #1;
    tgt     = m_hv ? model_target(m_rt, m_ct) : '0;
    fire    = m_hv && ((tgt & ~pe_ready) == '0);
    exp_rdy = m_run && !cfg_start && (!m_hv || fire);
    chk("pe_valid", 256'(pe_valid), 256'(tgt));
    chk("pe_data", 256'(pe_data), 256'(m_data));
    chk("in_ready", 256'(in_ready), 256'(exp_rdy));
    chk("drop_cnt", 256'(drop_cnt), 256'(m_drop));
    if (fire) begin
      n_fires++;
      if (tgt == '0) begin
        if (m_drop != 16'hFFFF) m_drop++;
      end else begin
        fired_q.push_back(m_data);
      end
    end
    m_acc = in_valid && exp_rdy;
    if (m_acc) begin
      m_hv   = 1;
      m_data = in_data;
      m_rt   = in_row_tag;
      m_ct   = in_col_tag;
    end else if (fire) begin
      m_hv = 0;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid = 0;
    pe_ready = '1;
    step();
    step();
  endtask

  task automatic send(input logic [ID_W-1:0] rt, input logic [ID_W-1:0] ct,
                      input logic [DATA_W-1:0] d);
    in_valid   = 1;
    in_row_tag = rt;
    in_col_tag = ct;
    in_data    = d;
  endtask

  // Full ID load from m_row/m_col; abort_after >= 0 stops after that many column IDs.
  task automatic load_cfg(input bit with_valid, input int abort_after);
    cfg_start = 1;
    in_valid  = with_valid;
    #1;
    chk("start_in_ready", 256'(in_ready), 256'(0));
    @(negedge clk);
    cfg_start = 0;
    in_valid  = 0;
    m_run     = 0;
    #1;
    chk("busy_in_load", 256'(cfg_busy), 256'(1));
    for (int k = 0; k < ROWS; k++) begin
      cfg_id_valid = 1;
      cfg_id       = m_row[k];
      @(negedge clk);
    end
    for (int k = 0; k < N; k++) begin
      if (k == abort_after) begin
        cfg_id_valid = 0;
        return;
      end
      cfg_id = m_col[k];
      @(negedge clk);
    end
    cfg_id_valid = 0;
    #1;
    chk("cfg_done_rise", 256'(cfg_done), 256'(1));
    chk("cfg_busy_end", 256'(cfg_busy), 256'(0));
    chk("in_ready_at_done", 256'(in_ready), 256'(1));
    m_run = 1;
    @(negedge clk);
    chk("cfg_done_pulse", 256'(cfg_done), 256'(0));
  endtask

  task automatic chk_reset_values();
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_pe_valid", 256'(pe_valid), 256'(0));
    chk("rst_pe_data", 256'(pe_data), 256'(0));
    chk("rst_cfg_busy", 256'(cfg_busy), 256'(0));
    chk("rst_cfg_done", 256'(cfg_done), 256'(0));
    chk("rst_drop_cnt", 256'(drop_cnt), 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{5'd3,  5'd5,  16'hBEEF, 1,   47};
    vecs[1] = '{BC,    5'd2,  16'h0102, 12,  2};
    vecs[2] = '{5'd0,  BC,    16'h0203, 14,  13};
    vecs[3] = '{BC,    BC,    16'h0304, 168, 167};
    vecs[4] = '{5'd20, 5'd20, 16'h0405, 0,   -1};
    vecs[5] = '{5'd11, 5'd13, 16'h0506, 1,   167};
    vecs[6] = '{5'd12, 5'd0,  16'h0607, 0,   -1};
    vecs[7] = '{5'd7,  BC,    16'h0708, 14,  98};

    rst = 1; cfg_start = 0; cfg_id_valid = 0; cfg_id = '0;
    in_valid = 0; in_data = '0; in_row_tag = '0; in_col_tag = '0; pe_ready = '1;
    n_fires = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk_reset_values();

    // cfg_id_valid without cfg_start must not start a load
    cfg_id_valid = 1;
    cfg_id       = 5'd3;
    @(negedge clk);
    chk("uncfg_ignore_id", 256'(cfg_busy), 256'(0));
    cfg_id_valid = 0;

    for (int r = 0; r < ROWS; r++) m_row[r] = ID_W'(r);
    for (int k = 0; k < N; k++) m_col[k] = ID_W'(k % COLS);
    load_cfg(0, -1);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].rt, vecs[i].ct, vecs[i].data);
      step();
      in_valid = 0;
      #1;
      chk("vec_cnt", 256'($countones(pe_valid)), 256'(vecs[i].cnt));
      if (vecs[i].bitn >= 0) chk("vec_bit", 256'(pe_valid[vecs[i].bitn]), 256'(1));
      chk("vec_data", 256'(pe_data), 256'(vecs[i].data));
      step();
    end

    // Stall column 2 broadcast on PE 30 for four cycles
    pe_ready     = '1;
    pe_ready[30] = 1'b0;
    send(BC, 5'd2, 16'hA5A5);
    step();
    send(5'd3, 5'd6, 16'h1234);
    repeat (4) begin
      #1;
      chk("stall_in_ready", 256'(in_ready), 256'(0));
      chk("stall_bit30", 256'(pe_valid[30]), 256'(1));
      chk("stall_data", 256'(pe_data), 256'(16'hA5A5));
      step();
    end
    pe_ready = '1;
    #1;
    chk("release_in_ready", 256'(in_ready), 256'(1));
    step();
    drain();

    // PE 47 disabled; cfg_start collides with in_valid on the first cycle
    m_col[47] = BC;
    send(5'd1, 5'd1, 16'hDEAD);
    load_cfg(1, -1);
    send(BC, BC, 16'h5A5A);
    step();
    in_valid = 0;
    #1;
    e_mask     = '1;
    e_mask[47] = 1'b0;
    chk("disable_mask", 256'(pe_valid), 256'(e_mask));
    step();

    // Back-to-back zero-target words
    base = m_drop;
    repeat (5) begin
      send(5'd20, 5'd20, 16'hD0D0);
      step();
    end
    in_valid = 0;
    step();
    chk("drop_burst", 256'(drop_cnt), 256'(base + 5));

    // Stream of ten words, all ready
    nf = n_fires;
    qs = fired_q.size();
    for (int i = 0; i < 10; i++) begin
      send(ID_W'(i % ROWS), BC, DATA_W'(16'h1000 + i));
      step();
    end
    in_valid = 0;
    step();
    chk("stream_fires", 256'(n_fires - nf), 256'(10));
    for (int i = 0; i < 10; i++) chk("stream_order", 256'(fired_q[qs+i]), 256'(16'h1000 + i));

    // Randomized traffic with random backpressure
    in_valid = 0;
    m_acc    = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!in_valid || m_acc) begin
        in_valid   = ($urandom_range(0, 3) != 0);
        in_data    = DATA_W'($urandom);
        in_row_tag = pick_tag();
        in_col_tag = pick_tag();
      end
      pe_ready = '1;
      if ($urandom_range(0, 3) == 0) pe_ready[$urandom_range(0, N - 1)] = 1'b0;
      step();
    end
    drain();

    // Reset in the middle of a column load
    load_cfg(0, 7);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    chk_reset_values();
    send(5'd3, 5'd6, 16'h7777);
    repeat (3) step();
    chk("post_rst_busy", 256'(cfg_busy), 256'(0));
    in_valid = 0;
    load_cfg(0, -1);
    send(5'd3, 5'd6, 16'h8888);
    step();
    in_valid = 0;
    #1;
    chk("reload_bit48", 256'(pe_valid[48]), 256'(1));
    chk("reload_cnt", 256'($countones(pe_valid)), 256'(1));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
